// File: rtl/lpc_pkg.sv
// rtl/lpc_pkg.sv - shared encodings, phase lengths and state type for the LPC initiator
// Purpose: cyctype/SYNC/nibble constants, phase lengths, FSM state enum and small
//          cyctype helpers used by lpc_host and lpc_nibble_shifter.
// Ports:   none (package).
package lpc_pkg;

   // Request cyctype_dir[3:2] encodings and the direction bit position.
   localparam logic [1:0] CYC_IO     = 2'b00;
   localparam logic [1:0] CYC_MEM    = 2'b01;
   localparam int         CYC_WR_BIT = 1;

   // The CYCTYPE nibble on LAD always carries bit 0 as zero.
   localparam logic [3:0] CYC_NIB_MASK = 4'b1110;

   // Peripheral SYNC codes.
   localparam logic [3:0] SYNC_READY = 4'b0000;
   localparam logic [3:0] SYNC_SHORT = 4'b0101;
   localparam logic [3:0] SYNC_LONG  = 4'b0110;
   localparam logic [3:0] SYNC_ERR   = 4'b1010;

   // Fixed LAD nibbles.
   localparam logic [3:0] NIB_ABORT = 4'b1111;
   localparam logic [3:0] NIB_START = 4'b0000;

   // Phase lengths in clocks.
   localparam logic [3:0] IO_ADDR_NIBS  = 4'd4;
   localparam logic [3:0] MEM_ADDR_NIBS = 4'd8;
   localparam logic [3:0] DATA_NIBS     = 4'd2;
   localparam logic [3:0] TAR_LEN       = 4'd2;
   localparam logic [3:0] RDATA_LEN     = 4'd2;
   localparam logic [3:0] PTAR_LEN      = 4'd2;
   localparam logic [3:0] ABORT_LEN     = 4'd4;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_CYCTYPE,
      ST_ADDR,
      ST_WDATA,
      ST_TAR,
      ST_SYNC,
      ST_RDATA,
      ST_PTAR,
      ST_ABORT,
      ST_ABORT_END,
      ST_DONE
   } lpc_state_e;

   function automatic logic cyctype_ok(input logic [3:0] cyc);
      return (cyc[3:2] == CYC_IO) || (cyc[3:2] == CYC_MEM);
   endfunction

   function automatic logic [3:0] addr_nibbles(input logic [3:0] cyc);
      return (cyc[3:2] == CYC_MEM) ? MEM_ADDR_NIBS : IO_ADDR_NIBS;
   endfunction

endpackage

// File: rtl/lpc_nibble_shifter.sv
// rtl/lpc_nibble_shifter.sv - MSB-first nibble serializer for LAD address/data phases
// Purpose: loads a 32-bit word left-justified and presents its top nibble each clock,
//          shifting on request; remaining_o is the count of nibbles still to follow
//          the one currently presented (0 on the last nibble).
// Ports:
//   lpc_clock    in   1   clock, posedge
//   lpc_reset    in   1   asynchronous, active-low reset
//   load_i       in   1   load load_data_i / load_count_i (wins over shift_i)
//   shift_i      in   1   advance to the next nibble
//   load_data_i  in   32  word to serialize, first nibble in [31:28]
//   load_count_i in   4   number of nibbles to emit (>= 1)
//   nibble_o     out  4   current nibble
//   remaining_o  out  4   nibbles left after the current one
module lpc_nibble_shifter
   import lpc_pkg::*;
(
   input  logic        lpc_clock,
   input  logic        lpc_reset,
   input  logic        load_i,
   input  logic        shift_i,
   input  logic [31:0] load_data_i,
   input  logic [3:0]  load_count_i,
   output logic [3:0]  nibble_o,
   output logic [3:0]  remaining_o
);

   logic [31:0] data_q, data_d;
   logic [3:0]  rem_q, rem_d;

   always_comb begin
      data_d = data_q;
      rem_d  = rem_q;
      if (load_i) begin
         data_d = load_data_i;
         rem_d  = load_count_i - 4'd1;
      end else if (shift_i) begin
         data_d = {data_q[27:0], 4'h0};
         if (rem_q != 4'd0) begin
            rem_d = rem_q - 4'd1;
         end
      end
   end

   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         data_q <= {8{NIB_ABORT}};
         rem_q  <= 4'd0;
      end else begin
         data_q <= data_d;
         rem_q  <= rem_d;
      end
   end

   assign nibble_o    = data_q[31:28];
   assign remaining_o = rem_q;

endmodule

// File: rtl/lpc_host.sv
// rtl/lpc_host.sv - LPC 1.1 bus initiator for single I/O and memory read/write cycles
// Purpose: accepts one request at a time, runs START/CYCTYPE/ADDR/[WDATA]/TAR/SYNC/
//          [RDATA]/PTAR on LAD[3:0]/LFRAME#, and returns read data and status as a
//          one-clock rsp_valid pulse. Invalid SYNC codes abort the cycle.
// Optional feature macro: LPC_SYNC_TIMEOUT_EN - abort after TIMEOUT_CYCLES consecutive
//          wait-SYNC clocks; without it wait SYNCs are honoured indefinitely.
// Ports:
//   lpc_clock        in   1   LPC clock, posedge
//   lpc_reset        in   1   asynchronous, active-low reset
//   req_valid/ready  in/out   request handshake, ready only in IDLE
//   req_cyctype_dir  in   4   [3:2] 00=I/O 01=mem, [1]=write
//   req_addr         in   32  address (I/O uses [15:0])
//   req_data         in   8   write data
//   rsp_valid        out  1   one-clock completion pulse
//   rsp_data         out  8   read data (0 for writes)
//   rsp_error        out  1   SYNC error, abort or rejected cyctype
//   lpc_frame        out  1   LFRAME#, active low
//   lpc_ad_out       out  4   LAD drive value
//   lpc_ad_oe        out  1   LAD output enable
//   lpc_ad_in        in   4   LAD sampled value
module lpc_host
   import lpc_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        lpc_clock,
   input  logic        lpc_reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_cyctype_dir,
   input  logic [31:0] req_addr,
   input  logic [7:0]  req_data,
   output logic        rsp_valid,
   output logic [7:0]  rsp_data,
   output logic        rsp_error,
   output logic        lpc_frame,
   output logic [3:0]  lpc_ad_out,
   output logic        lpc_ad_oe,
   input  logic [3:0]  lpc_ad_in
);

`ifdef LPC_SYNC_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif
   // Compared on the last allowed wait clock, so the abort starts right after it.
   localparam logic [15:0] SYNC_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   lpc_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  cyc_q, cyc_d;
   logic [31:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        serr_q, serr_d;
   logic [15:0] sync_wait_q, sync_wait_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [7:0]  rsp_data_q, rsp_data_d;
   logic        rsp_error_q, rsp_error_d;

   logic        sh_load, sh_shift;
   logic [31:0] sh_data;
   logic [3:0]  sh_count, sh_nibble, sh_rem;

   logic        is_write;
   assign is_write = cyc_q[CYC_WR_BIT];

   lpc_nibble_shifter u_shifter (
      .lpc_clock    (lpc_clock),
      .lpc_reset    (lpc_reset),
      .load_i       (sh_load),
      .shift_i      (sh_shift),
      .load_data_i  (sh_data),
      .load_count_i (sh_count),
      .nibble_o     (sh_nibble),
      .remaining_o  (sh_rem)
   );

   always_ff @(posedge lpc_clock or negedge lpc_reset) begin
      if (!lpc_reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         cyc_q       <= 4'd0;
         addr_q      <= 32'd0;
         wdata_q     <= 8'd0;
         rdata_q     <= 8'd0;
         serr_q      <= 1'b0;
         sync_wait_q <= 16'd0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= 8'd0;
         rsp_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cyc_q       <= cyc_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         serr_q      <= serr_d;
         sync_wait_q <= sync_wait_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cyc_d       = cyc_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      serr_d      = serr_q;
      sync_wait_d = sync_wait_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_error_d = rsp_error_q;
      sh_load     = 1'b0;
      sh_shift    = 1'b0;
      sh_data     = 32'd0;
      sh_count    = 4'd0;
      lpc_frame   = 1'b1;
      lpc_ad_oe   = 1'b0;
      lpc_ad_out  = NIB_ABORT;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               cyc_d   = req_cyctype_dir;
               addr_d  = req_addr;
               wdata_d = req_data;
               rdata_d = 8'd0;
               serr_d  = 1'b0;
               if (cyctype_ok(req_cyctype_dir)) begin
                  state_d = ST_START;
               end else begin
                  // Rejected requests never touch the bus.
                  serr_d  = 1'b1;
                  state_d = ST_DONE;
               end
            end
         end

         ST_START: begin
            lpc_frame  = 1'b0;
            lpc_ad_oe  = 1'b1;
            lpc_ad_out = NIB_START;
            state_d    = ST_CYCTYPE;
         end

         ST_CYCTYPE: begin
            lpc_ad_oe  = 1'b1;
            lpc_ad_out = cyc_q & CYC_NIB_MASK;
            // I/O addresses are left-justified so both sizes leave MSB first.
            sh_load    = 1'b1;
            sh_count   = addr_nibbles(cyc_q);
            sh_data    = (cyc_q[3:2] == CYC_MEM) ? addr_q : {addr_q[15:0], 16'd0};
            state_d    = ST_ADDR;
         end

         ST_ADDR: begin
            lpc_ad_oe  = 1'b1;
            lpc_ad_out = sh_nibble;
            sh_shift   = 1'b1;
            if (sh_rem == 4'd0) begin
               if (is_write) begin
                  // Data goes out low nibble first, so swap before serializing.
                  sh_load  = 1'b1;
                  sh_count = DATA_NIBS;
                  sh_data  = {wdata_q[3:0], wdata_q[7:4], 24'd0};
                  state_d  = ST_WDATA;
               end else begin
                  cnt_d   = TAR_LEN - 4'd1;
                  state_d = ST_TAR;
               end
            end
         end

         ST_WDATA: begin
            lpc_ad_oe  = 1'b1;
            lpc_ad_out = sh_nibble;
            sh_shift   = 1'b1;
            if (sh_rem == 4'd0) begin
               cnt_d   = TAR_LEN - 4'd1;
               state_d = ST_TAR;
            end
         end

         ST_TAR: begin
            if (cnt_q != 4'd0) begin
               lpc_ad_oe  = 1'b1;
               lpc_ad_out = NIB_ABORT;
               cnt_d      = cnt_q - 4'd1;
            end else begin
               sync_wait_d = 16'd0;
               state_d     = ST_SYNC;
            end
         end

         ST_SYNC: begin
            case (lpc_ad_in)
               SYNC_READY, SYNC_ERR: begin
                  if (lpc_ad_in == SYNC_ERR) begin
                     serr_d = 1'b1;
                  end
                  if (is_write) begin
                     cnt_d   = PTAR_LEN - 4'd1;
                     state_d = ST_PTAR;
                  end else begin
                     cnt_d   = RDATA_LEN - 4'd1;
                     state_d = ST_RDATA;
                  end
               end
               SYNC_SHORT, SYNC_LONG: begin
                  if (TIMEOUT_EN && (sync_wait_q == SYNC_LIMIT)) begin
                     cnt_d   = ABORT_LEN - 4'd1;
                     state_d = ST_ABORT;
                  end else if (TIMEOUT_EN) begin
                     sync_wait_d = sync_wait_q + 16'd1;
                  end
               end
               default: begin
                  cnt_d   = ABORT_LEN - 4'd1;
                  state_d = ST_ABORT;
               end
            endcase
         end

         ST_RDATA: begin
            if (cnt_q != 4'd0) begin
               rdata_d[3:0] = lpc_ad_in;
               cnt_d        = cnt_q - 4'd1;
            end else begin
               rdata_d[7:4] = lpc_ad_in;
               cnt_d        = PTAR_LEN - 4'd1;
               state_d      = ST_PTAR;
            end
         end

         ST_PTAR: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = ST_DONE;
            end
         end

         ST_ABORT: begin
            lpc_frame  = 1'b0;
            lpc_ad_oe  = 1'b1;
            lpc_ad_out = NIB_ABORT;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = ST_ABORT_END;
            end
         end

         ST_ABORT_END: begin
            serr_d  = 1'b1;
            state_d = ST_DONE;
         end

         ST_DONE: begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = is_write ? 8'd0 : rdata_q;
            rsp_error_d = serr_q;
            state_d     = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_lpc_host.sv
// tb/tb_lpc_host.sv - directed self-checking bench for lpc_host
module tb_lpc_host;

   logic        lpc_clock = 1'b0;
   logic        lpc_reset;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_cyctype_dir;
   logic [31:0] req_addr;
   logic [7:0]  req_data;
   logic        rsp_valid;
   logic [7:0]  rsp_data;
   logic        rsp_error;
   logic        lpc_frame;
   logic [3:0]  lpc_ad_out;
   logic        lpc_ad_oe;
   logic [3:0]  lpc_ad_in;

   int n_checks = 0;
   int n_fail   = 0;

   // Per-cycle expected {rsp_valid, frame, oe, ad (0 when not driven)}.
   logic [6:0] exp_bus[$];
   // Peripheral LAD value to present during cycle k after accept.
   logic [3:0] ad_script[int];

   lpc_host #(.TIMEOUT_CYCLES(16)) dut (
      .lpc_clock       (lpc_clock),
      .lpc_reset       (lpc_reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_cyctype_dir (req_cyctype_dir),
      .req_addr        (req_addr),
      .req_data        (req_data),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .rsp_error       (rsp_error),
      .lpc_frame       (lpc_frame),
      .lpc_ad_out      (lpc_ad_out),
      .lpc_ad_oe       (lpc_ad_oe),
      .lpc_ad_in       (lpc_ad_in)
   );

   always #5 lpc_clock = ~lpc_clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic f, input logic oe, input logic [3:0] ad, input int n);
      for (int i = 0; i < n; i++) exp_bus.push_back({1'b0, f, oe, oe ? ad : 4'h0});
   endtask

   task automatic hdr(input logic [3:0] cyc_nib);
      push(1'b0, 1'b1, 4'h0, 1);
      push(1'b1, 1'b1, cyc_nib, 1);
   endtask

   task automatic drv(input logic [3:0] v);
      push(1'b1, 1'b1, v, 1);
   endtask

   task automatic off(input int n);
      push(1'b1, 1'b0, 4'h0, n);
   endtask

   task automatic run_txn(input string name, input logic [3:0] cyc, input logic [31:0] addr,
                          input logic [7:0] data, input int lat,
                          input logic [7:0] exp_d, input logic exp_e);
      @(negedge lpc_clock);
      check({name, ".req_ready"}, 32'(req_ready), 32'd1);
      check({name, ".exp_len"}, 32'(exp_bus.size()), 32'(lat));
      req_valid       = 1'b1;
      req_cyctype_dir = cyc;
      req_addr        = addr;
      req_data        = data;
      for (int k = 1; k <= lat + 1; k++) begin
         @(negedge lpc_clock);
         req_valid = 1'b0;
         if (k <= lat) begin
            check($sformatf("%s.bus%0d", name, k),
                  32'({rsp_valid, lpc_frame, lpc_ad_oe, lpc_ad_oe ? lpc_ad_out : 4'h0}),
                  32'(exp_bus[k-1]));
         end
         lpc_ad_in = ad_script.exists(k) ? ad_script[k] : 4'hF;
      end
      check({name, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({name, ".rsp_data"},  32'(rsp_data),  32'(exp_d));
      check({name, ".rsp_error"}, 32'(rsp_error), 32'(exp_e));
      @(negedge lpc_clock);
      check({name, ".rsp_pulse"}, 32'(rsp_valid), 32'd0);
      lpc_ad_in = 4'hF;
      exp_bus.delete();
      ad_script.delete();
   endtask

   initial begin
      lpc_reset       = 1'b0;
      req_valid       = 1'b0;
      req_cyctype_dir = 4'h0;
      req_addr        = 32'h0;
      req_data        = 8'h0;
      lpc_ad_in       = 4'hF;
      #1;
      check("rst.frame", 32'(lpc_frame), 32'd1);
      check("rst.oe", 32'(lpc_ad_oe), 32'd0);
      check("rst.ad", 32'(lpc_ad_out), 32'hF);
      check("rst.rsp", 32'({rsp_valid, rsp_error, rsp_data}), 32'd0);
      repeat (2) @(negedge lpc_clock);
      lpc_reset = 1'b1;

      // I/O write 0x0080 <= 0xA5, ready SYNC
      hdr(4'h2); drv(4'h0); drv(4'h0); drv(4'h8); drv(4'h0);
      drv(4'h5); drv(4'hA); drv(4'hF); off(1); off(1); off(2); off(1);
      ad_script[11] = 4'h0;
      run_txn("io_wr", 4'b0010, 32'h0000_0080, 8'hA5, 14, 8'h00, 1'b0);

      // Memory read 0xFFFF_FFF0, two long waits, data 0xC3
      hdr(4'h4);
      for (int i = 0; i < 7; i++) drv(4'hF);
      drv(4'h0); drv(4'hF); off(1); off(3); off(2); off(2); off(1);
      ad_script[13] = 4'h6; ad_script[14] = 4'h6; ad_script[15] = 4'h0;
      ad_script[16] = 4'h3; ad_script[17] = 4'hC;
      run_txn("mem_rd", 4'b0100, 32'hFFFF_FFF0, 8'h00, 20, 8'hC3, 1'b0);

      // Rejected cyctype: no bus activity, error response next clock
      off(1);
      run_txn("reject", 4'b1000, 32'h1234_5678, 8'h55, 1, 8'h00, 1'b1);

      // I/O read with error SYNC still returns the data
      hdr(4'h0); drv(4'h0); drv(4'h0); drv(4'h2); drv(4'hE);
      drv(4'hF); off(1); off(1); off(2); off(2); off(1);
      ad_script[9] = 4'hA; ad_script[10] = 4'hE; ad_script[11] = 4'h7;
      run_txn("io_rd_err", 4'b0000, 32'h0000_002E, 8'h00, 14, 8'h7E, 1'b1);
      repeat (3) @(negedge lpc_clock);
      check("hold.data", 32'(rsp_data), 32'h7E);
      check("hold.err", 32'(rsp_error), 32'd1);

      // I/O write with one short wait; error from previous cycle must clear
      hdr(4'h2); drv(4'h0); drv(4'h3); drv(4'hF); drv(4'h8);
      drv(4'hC); drv(4'h5); drv(4'hF); off(1); off(2); off(2); off(1);
      ad_script[11] = 4'h5; ad_script[12] = 4'h0;
      run_txn("io_wr_wait", 4'b0011, 32'hABCD_03F8, 8'h5C, 15, 8'h00, 1'b0);

      // Invalid SYNC code aborts
      hdr(4'h0); drv(4'h0); drv(4'h0); drv(4'h6); drv(4'h0);
      drv(4'hF); off(1); off(1); push(1'b0, 1'b1, 4'hF, 4); off(1); off(1);
      ad_script[9] = 4'h3;
      run_txn("abort", 4'b0000, 32'h0000_0060, 8'h00, 15, 8'h00, 1'b1);

`ifdef LPC_SYNC_TIMEOUT_EN
      // Long wait held past the 16-clock limit
      hdr(4'h0); drv(4'h0); drv(4'h0); drv(4'h7); drv(4'h0);
      drv(4'hF); off(1); off(16); push(1'b0, 1'b1, 4'hF, 4); off(1); off(1);
      for (int k = 9; k <= 24; k++) ad_script[k] = 4'h6;
      run_txn("timeout", 4'b0000, 32'h0000_0070, 8'h00, 30, 8'h00, 1'b1);
`endif

      // Reset in the middle of the address phase
      @(negedge lpc_clock);
      req_valid       = 1'b1;
      req_cyctype_dir = 4'b0010;
      req_addr        = 32'h0000_0080;
      req_data        = 8'h11;
      repeat (3) @(negedge lpc_clock);
      req_valid = 1'b0;
      check("mid.oe_before", 32'({lpc_frame, lpc_ad_oe}), 32'b11);
      #2;
      lpc_reset = 1'b0;
      #1;
      check("mid.frame", 32'(lpc_frame), 32'd1);
      check("mid.oe", 32'(lpc_ad_oe), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge lpc_clock);
         check($sformatf("mid.no_rsp%0d", i), 32'(rsp_valid), 32'd0);
      end
      lpc_reset = 1'b1;
      @(negedge lpc_clock);
      check("mid.ready", 32'(req_ready), 32'd1);
      check("mid.rsp", 32'({rsp_valid, rsp_error, lpc_frame}), 32'b001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
